mem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the single-port 8-bit x 8K memory.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, FSM state and request types for mem_arbiter
package mem_arb_pkg;

   localparam int MEM_ADDR_W = 13;
   localparam int MEM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   // Sized by the package widths, so top-level width overrides must move together with these.
   typedef struct packed {
      logic                  we;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between the fetch and data ports
// MEM_ARB_RR_EN: alternate on conflict (grant the port that did not win last); otherwise port 1 always wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic any_o,
   output logic winner_o
);

   always_comb begin
      any_o = req0_i | req1_i;
`ifdef MEM_ARB_RR_EN
      if (req0_i && req1_i) begin
         winner_o = ~last_i;
      end else begin
         winner_o = req1_i;
      end
`else
      winner_o = req1_i;
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter/sequencer for the single-port 8-bit x 8K memory
// Conflict policy selected by MEM_ARB_RR_EN (round-robin) versus default fixed priority to port 1.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rd
);

   arb_state_t        state_q, state_d;
   logic              cur_q, cur_d;
   logic              last_q, last_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wr_q, mem_wr_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_read_q, mem_read_d;

   logic              any_req;
   logic              winner;
   mem_req_t          sel;

   mem_arb_pick u_pick (
      .req0_i   (req0),
      .req1_i   (req1),
      .last_i   (last_q),
      .any_o    (any_req),
      .winner_o (winner)
   );

   always_comb begin
      sel = '0;
      if (winner) begin
         sel.we    = we1;
         sel.addr  = addr1;
         sel.wdata = wdata1;
      end else begin
         sel.we    = we0;
         sel.addr  = addr0;
         sel.wdata = wdata0;
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wr_d    = mem_wr_q;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               mem_addr_d  = sel.addr;
               mem_wr_d    = sel.wdata;
               mem_write_d = sel.we;
               mem_read_d  = ~sel.we;
               gnt0_d      = ~winner;
               gnt1_d      = winner;
               cur_d       = winner;
               last_d      = winner;
               state_d     = ACCESS;
            end
         end
         // Memory strobes stay up for the whole cycle; read data is taken at its closing edge.
         ACCESS: begin
            if (mem_read_q) begin
               rdata_d = mem_rd;
            end
            rvalid0_d = ~cur_q;
            rvalid1_d = cur_q;
            state_d   = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_q       <= 1'b0;
         last_q      <= 1'b1;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wr_q    <= '0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wr_q    <= mem_wr_d;
         mem_write_q <= mem_write_d;
         mem_read_q  <= mem_read_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wr    = mem_wr_q;
   assign mem_write = mem_write_q;
   assign mem_read  = mem_read_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
// Expectations follow MEM_ARB_RR_EN when defined (round-robin), fixed priority otherwise.
module tb_mem_arbiter;

   localparam int AW = 13;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst, req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1, mem_addr;
   logic [DW-1:0] wdata0, wdata1, rdata, mem_wr, mem_rd;
   logic          gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr),
      .mem_write(mem_write), .mem_read(mem_read), .mem_rd(mem_rd)
   );

   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wr;
   assign mem_rd = mem[mem_addr];

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   txn_t          q0[$], q1[$];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int            cyc, free_cyc, exp_gnt, popped_cyc, first_gnt_cyc;
   bit            m_last, exp_active, exp_port, gap_en;
   txn_t          exp_t;
   logic [DW-1:0] exp_rdata, m_rdata, last_rv_data;
   int            n_checks, n_fail;
   int            gnt_log[$];
   int            gnt0_cyc_log[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      logic [AW-1:0] a;
      a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      if ($urandom_range(0, 7) == 0) a = '1;
      return mk(1'($urandom), a, DW'($urandom));
   endfunction

   // Arbiter abstraction: a grant lands one cycle after the first free cycle seeing a request,
   // and the arbiter is free again three cycles after it decides.
   task automatic model_eval();
      txn_t t;
      bit   w;
      if (rst) begin
         exp_active = 1'b0;
         free_cyc   = cyc + 1;
         m_last     = 1'b1;
         m_rdata    = '0;
      end else if (cyc >= free_cyc && (req0 || req1)) begin
`ifdef MEM_ARB_RR_EN
         w = (req0 && req1) ? !m_last : req1;
`else
         w = req1;
`endif
         t          = w ? mk(we1, addr1, wdata1) : mk(we0, addr0, wdata0);
         exp_active = 1'b1;
         exp_gnt    = cyc + 1;
         exp_port   = w;
         exp_t      = t;
         if (t.we) ref_mem[t.addr] = t.wdata;
         else      m_rdata = ref_mem[t.addr];
         exp_rdata  = m_rdata;
         free_cyc   = cyc + 3;
         m_last     = w;
      end
   endtask

   task automatic check_cycle();
      bit g, v;
      g = exp_active && cyc == exp_gnt;
      v = exp_active && cyc == exp_gnt + 1;
      check_eq("gnt0", 32'(gnt0), 32'(g && !exp_port));
      check_eq("gnt1", 32'(gnt1), 32'(g && exp_port));
      check_eq("rvalid0", 32'(rvalid0), 32'(v && !exp_port));
      check_eq("rvalid1", 32'(rvalid1), 32'(v && exp_port));
      if (g) begin
         check_eq("mem_addr", 32'(mem_addr), 32'(exp_t.addr));
         check_eq("mem_write", 32'(mem_write), 32'(exp_t.we));
         check_eq("mem_read", 32'(mem_read), 32'(!exp_t.we));
         if (exp_t.we) check_eq("mem_wr", 32'(mem_wr), 32'(exp_t.wdata));
      end else begin
         check_eq("mem_write_quiet", 32'(mem_write), 32'(0));
         check_eq("mem_read_quiet", 32'(mem_read), 32'(0));
      end
      if (v) check_eq("rdata", 32'(rdata), 32'(exp_rdata));
      if (gnt0) begin gnt_log.push_back(0); gnt0_cyc_log.push_back(cyc); end
      if (gnt1) gnt_log.push_back(1);
      if ((gnt0 || gnt1) && first_gnt_cyc < 0) first_gnt_cyc = cyc;
      if (rvalid0 || rvalid1) last_rv_data = rdata;
   endtask

   task automatic drive_ports();
      if (exp_active && cyc == exp_gnt && popped_cyc != cyc) begin
         popped_cyc = cyc;
         if (exp_port) begin q1.delete(0); req1 = 1'b0; end
         else          begin q0.delete(0); req0 = 1'b0; end
      end
      if (!req0 && q0.size() > 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
         req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
      end else if (!req0) begin
         we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
      end
      if (!req1 && q1.size() > 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
         req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
      end else if (!req1) begin
         we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
      end
   endtask

   task automatic run_cycle();
      model_eval();
      @(negedge clk);
      cyc++;
      check_cycle();
      drive_ports();
   endtask

   task automatic drain();
      int n;
      n = 0;
      drive_ports();
      while ((q0.size() > 0 || q1.size() > 0 || cyc <= free_cyc) && n < 300) begin
         run_cycle();
         n++;
      end
      check_eq("drain_timeout", 32'(n >= 300), 32'(0));
   endtask

   initial begin
      int n;
      int pat[4];
      n_checks = 0; n_fail = 0;
      cyc = 0; free_cyc = 0; popped_cyc = -1; first_gnt_cyc = -1;
      m_last = 1'b1; exp_active = 1'b0; exp_gnt = -10; exp_port = 1'b0;
      m_rdata = '0; exp_rdata = '0; last_rv_data = '0; gap_en = 1'b0;
      exp_t = mk(1'b0, '0, '0);
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]     = DW'($urandom);
         ref_mem[i] = mem[i];
      end
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // 1: reset held two cycles with both ports requesting
      q0.push_back(mk(1'b0, 13'h0100, 8'h00));
      q1.push_back(mk(1'b0, 13'h0200, 8'h00));
      drive_ports();
      for (int i = 0; i < 2; i++) begin
         run_cycle();
         check_eq("rst_rdata", 32'(rdata), 32'(0));
         check_eq("rst_mem_addr", 32'(mem_addr), 32'(0));
         check_eq("rst_mem_wr", 32'(mem_wr), 32'(0));
      end
      rst = 1'b0;
      drain();
      check_eq("first_gnt_cycle", 32'(first_gnt_cyc), 32'(3));

      // 2: write through port 1, read back through port 0
      q1.push_back(mk(1'b1, 13'h03E8, 8'hA5));
      drain();
      q0.push_back(mk(1'b0, 13'h03E8, 8'h00));
      drain();
      check_eq("t2_readback", 32'(last_rv_data), 32'(8'hA5));

      // 3: sustained conflict starting from last = 1
      rst = 1'b1;
      run_cycle();
      rst = 1'b0;
      gnt_log.delete();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(mk(1'b0, AW'($urandom), 8'h00));
         q1.push_back(mk(1'b0, AW'($urandom), 8'h00));
      end
      drain();
`ifdef MEM_ARB_RR_EN
      pat[0] = 0; pat[1] = 1; pat[2] = 0; pat[3] = 1;
`else
      pat[0] = 1; pat[1] = 1; pat[2] = 1; pat[3] = 1;
`endif
      check_eq("t3_grant_count", 32'(gnt_log.size()), 32'(8));
      for (int i = 0; i < 4; i++) check_eq("t3_grant_order", 32'(gnt_log[i]), 32'(pat[i]));

      // 4: back-to-back port 0 reads of the preloaded low addresses
      gnt0_cyc_log.delete();
      for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, AW'(i), 8'h00));
      drain();
      check_eq("t4_grant_count", 32'(gnt0_cyc_log.size()), 32'(4));
      for (int i = 1; i < 4; i++)
         check_eq("t4_spacing", 32'(gnt0_cyc_log[i] - gnt0_cyc_log[i-1]), 32'(3));

      // 5: reset during the ACCESS cycle of a read
      q0.push_back(mk(1'b0, 13'h0042, 8'h00));
      drive_ports();
      n = 0;
      while (!(exp_active && cyc == exp_gnt) && n < 20) begin
         run_cycle();
         n++;
      end
      check_eq("t5_reach_access", 32'(n < 20), 32'(1));
      rst = 1'b1;
      run_cycle();
      rst = 1'b0;
      check_eq("t5_no_rvalid", 32'(rvalid0), 32'(0));
      check_eq("t5_mem_read_low", 32'(mem_read), 32'(0));
      q0.push_back(mk(1'b0, 13'h0043, 8'h00));
      drive_ports();
      run_cycle();
      check_eq("t5_idle_regrant", 32'(gnt0), 32'(1));
      drain();

      // 6: top address, and rdata holding across a write
      q1.push_back(mk(1'b1, 13'h1FFF, 8'hFF));
      drain();
      q0.push_back(mk(1'b0, 13'h1FFF, 8'h00));
      drain();
      check_eq("t6_top_readback", 32'(last_rv_data), 32'(8'hFF));
      q1.push_back(mk(1'b1, 13'h0010, 8'h3C));
      drain();
      check_eq("t6_rdata_hold", 32'(rdata), 32'(8'hFF));

      // randomized traffic with idle gaps and occasional resets
      gap_en = 1'b1;
      for (int i = 0; i < 50; i++) begin
         q0.push_back(rand_txn());
         q1.push_back(rand_txn());
      end
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 4000) begin
         rst = ($urandom_range(0, 99) < 2);
         run_cycle();
         n++;
      end
      rst = 1'b0;
      check_eq("rand_timeout", 32'(n >= 4000), 32'(0));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
